// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: turns framed UART command bytes into single register-bus transactions with a status reply.
// Define UART_REG_CTRL_CKSUM_EN to require a trailing modulo-256 checksum byte on every frame.
module uart_reg_ctrl #(
    parameter int GAP_TICKS   = 480,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       x16clk_i,
    input  logic       rx_wr_i,
    input  logic [7:0] rx_data_i,
    output logic       reg_we_o,
    output logic       reg_re_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    input  logic [7:0] reg_rdata_i,
    input  logic       reg_ack_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       rx_drop_o
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, BUS, WAIT_ACK, REPLY0, REPLY1} state_e;
    localparam logic [7:0] CMD_W = 8'h57, CMD_R = 8'h52, ACK = 8'h06, NAK = 8'h15;
`ifdef UART_REG_CTRL_CKSUM_EN
    localparam state_e LAST = CSUM;
`else
    localparam state_e LAST = BUS;
`endif
    state_e      state_q, state_d;
    logic        wr_q, wr_d, two_q, two_d, drop_q, drop_d;
    logic [7:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, tx_q, tx_d, ack_q, ack_d;
    logic [11:0] gap_q, gap_d;
    logic        collect, gap_fire;
    assign collect  = state_q inside {ADDR, DATA, CSUM};
    assign gap_fire = collect && gap_q == 12'(GAP_TICKS);
    assign gap_d    = (!collect || rx_wr_i) ? '0 : gap_q + 12'(x16clk_i);
    assign ack_d    = state_q == WAIT_ACK ? ack_q + 8'd1 : '0;
    // A byte is lost whenever it arrives outside frame collection, or collides with the gap timeout.
    assign drop_d   = rx_wr_i && (gap_fire || !(state_q inside {IDLE, ADDR, DATA, CSUM}));
`ifdef UART_REG_CTRL_CKSUM_EN
    logic [7:0] sum_q, sum_d;
    assign sum_d = !rx_wr_i ? sum_q : state_q == IDLE ? rx_data_i : sum_q + rx_data_i;
    always_ff @(posedge clk_i)
        sum_q <= !rst_n_i ? '0 : sum_d;
`endif
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        two_d   = two_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: if (rx_wr_i) begin
                if (rx_data_i == CMD_W || rx_data_i == CMD_R) begin
                    wr_d    = rx_data_i == CMD_W;
                    state_d = ADDR;
                end else begin
                    tx_d    = NAK;
                    two_d   = 1'b0;
                    state_d = REPLY0;
                end
            end
            ADDR: if (gap_fire) state_d = IDLE;
            else if (rx_wr_i) begin
                addr_d  = rx_data_i;
                state_d = wr_q ? DATA : LAST;
            end
            DATA: if (gap_fire) state_d = IDLE;
            else if (rx_wr_i) begin
                wdata_d = rx_data_i;
                state_d = LAST;
            end
`ifdef UART_REG_CTRL_CKSUM_EN
            CSUM: if (gap_fire) state_d = IDLE;
            else if (rx_wr_i) begin
                tx_d    = NAK;
                two_d   = 1'b0;
                state_d = rx_data_i == sum_q ? BUS : REPLY0;
            end
`endif
            BUS: state_d = WAIT_ACK;
            WAIT_ACK: if (reg_ack_i) begin
                tx_d    = ACK;
                two_d   = !wr_q;
                rdata_d = reg_rdata_i;
                state_d = REPLY0;
            end else if (ack_q == 8'(ACK_TIMEOUT - 1)) begin
                tx_d    = NAK;
                two_d   = 1'b0;
                state_d = REPLY0;
            end
            REPLY0: if (tx_ready_i) begin
                tx_d    = two_q ? rdata_q : tx_q;
                state_d = two_q ? REPLY1 : IDLE;
            end
            REPLY1: if (tx_ready_i) state_d = IDLE;
            default: ;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            two_q   <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tx_q    <= '0;
            ack_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            two_q   <= two_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
        end
    end
    assign reg_we_o    = state_q == BUS && wr_q;
    assign reg_re_o    = state_q == BUS && !wr_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign tx_valid_o  = state_q inside {REPLY0, REPLY1};
    assign tx_data_o   = tx_q;
    assign busy_o      = state_q != IDLE;
    assign rx_drop_o   = drop_q;
endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb_uart_reg_ctrl: table vectors, hand-timed corner sequences and random frames against a frame-level model.
module tb_uart_reg_ctrl;
    localparam int GAP = 20, ACKT = 255, NEVER = 9999;
    localparam logic [7:0] W = 8'h57, R = 8'h52, ACK = 8'h06, NAK = 8'h15;
    logic clk_i = 0, rst_n_i = 0, x16clk_i = 0, rx_wr_i = 0, reg_ack_i = 0, tx_ready_i = 0;
    logic [7:0] rx_data_i = 0, reg_rdata_i = 0;
    logic reg_we_o, reg_re_o, tx_valid_o, busy_o, rx_drop_o;
    logic [7:0] reg_addr_o, reg_wdata_o, tx_data_o;
    int checks = 0, errors = 0;

    uart_reg_ctrl #(.GAP_TICKS(GAP), .ACK_TIMEOUT(ACKT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .x16clk_i(x16clk_i), .rx_wr_i(rx_wr_i), .rx_data_i(rx_data_i),
        .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_rdata_i(reg_rdata_i), .reg_ack_i(reg_ack_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
        .tx_ready_i(tx_ready_i), .busy_o(busy_o), .rx_drop_o(rx_drop_o)
    );

    always #5 clk_i = ~clk_i;
    initial forever begin
        repeat (3) @(posedge clk_i);
        #1 x16clk_i = 1;
        @(posedge clk_i);
        #1 x16clk_i = 0;
    end

    typedef struct {
        logic [7:0] b0, b1, b2; int n; int dly; logic [7:0] rd; int stall; int drop_at;
        int e_we, e_re; logic [7:0] e_addr, e_wdata; int e_ntx; logic [7:0] e_tx0, e_tx1; int e_drop;
    } vec_t;

    // Observed bus strobes, accepted reply bytes, drop pulses and reply-byte stability.
    int n_we = 0, n_re = 0, n_drop = 0, stab_err = 0;
    logic [7:0] s_addr = 0, s_wdata = 0, pend_d = 0;
    logic pend = 0;
    logic [7:0] tx_log[$];
    always @(negedge clk_i) begin
        if (reg_we_o) begin n_we++; s_addr = reg_addr_o; s_wdata = reg_wdata_o; end
        if (reg_re_o) begin n_re++; s_addr = reg_addr_o; end
        if (rx_drop_o) n_drop++;
        if (pend && tx_valid_o && tx_data_o != pend_d) stab_err++;
        if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_data_o);
        pend = tx_valid_o && !tx_ready_i;
        pend_d = tx_data_o;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] fr[$], input bit full);
        logic [7:0] f[$];
        f = fr;
`ifdef UART_REG_CTRL_CKSUM_EN
        begin
            logic [7:0] s;
            s = 0;
            foreach (f[i]) s = s + f[i];
            if (full) f.push_back(s);
        end
`endif
        for (int i = 0; i < f.size(); i++) begin
            rx_wr_i = 1; rx_data_i = f[i];
            tick;
            rx_wr_i = 0; rx_data_i = 8'($urandom);
            if (i + 1 < f.size()) repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t e;
        bit ok;
        e = v;
        e.e_we = 0; e.e_re = 0; e.e_ntx = 0; e.e_drop = 0;
        e.e_addr = v.b1; e.e_wdata = v.b2; e.e_tx0 = 0; e.e_tx1 = v.rd;
        if (v.b0 != W && v.b0 != R) begin
            e.e_ntx = 1; e.e_tx0 = NAK;
        end else if (v.n >= (v.b0 == W ? 3 : 2)) begin
            ok = v.dly >= 1 && v.dly <= ACKT;
            e.e_we = int'(v.b0 == W); e.e_re = int'(v.b0 == R);
            e.e_ntx = (ok && v.b0 == R) ? 2 : 1;
            e.e_tx0 = ok ? ACK : NAK;
        end
        return e;
    endfunction

    task automatic run(input vec_t v, input string nm);
        logic [7:0] f[$];
        int we0, re0, dr0, tx0, se0, sc, st;
        bit full;
        we0 = n_we; re0 = n_re; dr0 = n_drop; tx0 = tx_log.size(); se0 = stab_err; sc = -1; st = 0;
        full = (v.b0 == W && v.n == 3) || (v.b0 == R && v.n == 2);
        f.push_back(v.b0);
        if (v.n > 1) f.push_back(v.b1);
        if (v.n > 2) f.push_back(v.b2);
        send(f, full);
        for (int c = 0; c < 800 && busy_o; c++) begin
            if (reg_we_o || reg_re_o) sc = 0; else if (sc >= 0) sc++;
            reg_ack_i = sc >= 0 && sc == v.dly;
            reg_rdata_i = reg_ack_i ? v.rd : 8'($urandom);
            rx_wr_i = sc >= 0 && sc == v.drop_at; rx_data_i = R;
            if (tx_valid_o) begin tx_ready_i = (st % (v.stall + 1)) == v.stall; st++; end
            else tx_ready_i = 0;
            tick;
        end
        reg_ack_i = 0; rx_wr_i = 0; tx_ready_i = 0;
        chk({nm, " idle"}, int'(busy_o), 0);
        chk({nm, " we"}, n_we - we0, v.e_we);
        chk({nm, " re"}, n_re - re0, v.e_re);
        if (v.e_we + v.e_re > 0) chk({nm, " addr"}, s_addr, v.e_addr);
        if (v.e_we > 0) chk({nm, " wdata"}, s_wdata, v.e_wdata);
        chk({nm, " ntx"}, tx_log.size() - tx0, v.e_ntx);
        if (v.e_ntx >= 1 && tx_log.size() > tx0) chk({nm, " tx0"}, tx_log[tx0], v.e_tx0);
        if (v.e_ntx >= 2 && tx_log.size() > tx0 + 1) chk({nm, " tx1"}, tx_log[tx0 + 1], v.e_tx1);
        chk({nm, " drop"}, n_drop - dr0, v.e_drop);
        chk({nm, " stable"}, stab_err - se0, 0);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        logic [7:0] hf[$];
        int we0;
        tbl[0] = '{W, 8'h10, 8'hA5, 3, 3, 8'h00, 0, NEVER, 1, 0, 8'h10, 8'hA5, 1, ACK, 8'h00, 0};
        tbl[1] = '{R, 8'h22, 8'h00, 2, 3, 8'h5C, 5, NEVER, 0, 1, 8'h22, 8'h00, 2, ACK, 8'h5C, 0};
        tbl[2] = '{8'h41, 8'h00, 8'h00, 1, NEVER, 8'h00, 0, NEVER, 0, 0, 8'h00, 8'h00, 1, NAK, 8'h00, 0};
        tbl[3] = '{W, 8'h33, 8'h44, 3, 0, 8'h00, 0, NEVER, 1, 0, 8'h33, 8'h44, 1, NAK, 8'h00, 0};
        tbl[4] = '{R, 8'h7F, 8'h00, 2, 255, 8'hAA, 1, NEVER, 0, 1, 8'h7F, 8'h00, 2, ACK, 8'hAA, 0};
        tbl[5] = '{W, 8'h01, 8'h02, 3, 256, 8'h00, 0, NEVER, 1, 0, 8'h01, 8'h02, 1, NAK, 8'h00, 0};
        tbl[6] = '{R, 8'h05, 8'h00, 2, 4, 8'hC3, 2, 1, 0, 1, 8'h05, 8'h00, 2, ACK, 8'hC3, 1};
        tbl[7] = '{W, 8'h00, 8'h00, 1, NEVER, 8'h00, 0, NEVER, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0};
        tbl[8] = '{R, 8'h00, 8'h00, 1, NEVER, 8'h00, 0, NEVER, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0};
        tbl[9] = '{R, 8'h6A, 8'h00, 2, 2, 8'h99, 0, NEVER, 0, 1, 8'h6A, 8'h00, 2, ACK, 8'h99, 0};

        repeat (3) tick;
        chk("rst tx_valid", int'(tx_valid_o), 0);
        chk("rst tx_data", tx_data_o, 0);
        chk("rst addr", reg_addr_o, 0);
        chk("rst wdata", reg_wdata_o, 0);
        chk("rst we", int'(reg_we_o), 0);
        chk("rst re", int'(reg_re_o), 0);
        chk("rst busy", int'(busy_o), 0);
        chk("rst drop", int'(rx_drop_o), 0);
        rst_n_i = 1;
        tick;

        hf = {W, 8'h10, 8'hA5};
        send(hf, 1);
        chk("strobe at N+1", int'(reg_we_o), 1);
        chk("strobe addr", reg_addr_o, 8'h10);
        chk("strobe wdata", reg_wdata_o, 8'hA5);
        tick;
        chk("strobe one cycle", int'(reg_we_o), 0);
        tick; tick;
        reg_ack_i = 1; tick; reg_ack_i = 0;
        chk("valid at M+1", int'(tx_valid_o), 1);
        chk("ack byte", tx_data_o, ACK);
        tx_ready_i = 1; tick; tx_ready_i = 0;
        chk("idle after reply", int'(busy_o), 0);

        hf = {8'h41};
        send(hf, 0);
        chk("nak at N+1", int'(tx_valid_o), 1);
        chk("nak byte", tx_data_o, NAK);
        tx_ready_i = 1; tick; tx_ready_i = 0;

        hf = {R, 8'h22};
        send(hf, 1);
        tick;
        reg_ack_i = 1; reg_rdata_i = 8'h5C; tick; reg_ack_i = 0;
        tx_ready_i = 1; tick; tx_ready_i = 0;
        chk("reply1 valid", int'(tx_valid_o), 1);
        chk("reply1 byte", tx_data_o, 8'h5C);
        rst_n_i = 0; tick; rst_n_i = 1;
        chk("rst reply valid", int'(tx_valid_o), 0);
        chk("rst reply busy", int'(busy_o), 0);
        chk("rst reply data", tx_data_o, 0);

        reg_ack_i = 1; tick; reg_ack_i = 0; tick;
        chk("stray ack busy", int'(busy_o), 0);
        chk("stray ack valid", int'(tx_valid_o), 0);

`ifdef UART_REG_CTRL_CKSUM_EN
        we0 = n_we;
        hf = {W, 8'h10, 8'hA5, 8'h00};
        send(hf, 0);
        chk("bad csum valid", int'(tx_valid_o), 1);
        chk("bad csum byte", tx_data_o, NAK);
        tx_ready_i = 1; tick; tx_ready_i = 0; tick;
        chk("bad csum no we", n_we - we0, 0);
`else
        we0 = 0;
`endif

        for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            v.b0 = r < 4 ? W : r < 8 ? R : 8'($urandom);
            v.b1 = 8'($urandom); v.b2 = 8'($urandom); v.rd = 8'($urandom);
            v.n = v.b0 == W ? 3 : v.b0 == R ? 2 : 1;
            if (v.n > 1 && $urandom_range(0, 7) == 0) v.n = v.n - 1;
            r = $urandom_range(0, 15);
            v.dly = r == 0 ? 0 : r == 1 ? 300 : $urandom_range(1, 6);
            v.stall = $urandom_range(0, 3);
            v.drop_at = NEVER;
            run(model(v), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_reg_ctrl.md
# uart_reg_ctrl

Command sequencer between the UART receiver's byte-strobe output and an 8-bit register bus. Collects framed command bytes (read/write), issues one bus transaction per command, and returns a status/data reply through a ready/valid byte port feeding the UART transmitter. It gives host software register access to the camera/display measurement logic over the serial link.

## Interface
Parameters:
- `GAP_TICKS`, default 480: inter-byte timeout in x16 ticks (= 30 bit times); range 1..4095.
- `ACK_TIMEOUT`, default 255: clk_i cycles to wait for `reg_ack_i`; range 1..255.

Ports:
- `clk_i`  in  1  single system clock.
- `rst_n_i`  in  1  reset, synchronous and active-low.
- `x16clk_i`  in  1  one-cycle enable at 16x baud rate.
- `rx_wr_i`  in  1  one-cycle strobe: `rx_data_i` holds a received byte.
- `rx_data_i`  in  8  received byte.
- `reg_we_o`  out  1  one-cycle write strobe.
- `reg_re_o`  out  1  one-cycle read strobe.
- `reg_addr_o`  out  8  register address; stable from strobe until ack/timeout.
- `reg_wdata_o`  out  8  write data; same stability as address.
- `reg_rdata_i`  in  8  read data, sampled in the `reg_ack_i` cycle.
- `reg_ack_i`  in  1  transaction complete.
- `tx_valid_o`  out  1  reply byte valid.
- `tx_data_o`  out  8  reply byte.
- `tx_ready_i`  in  1  transmitter accepts the byte when high with `tx_valid_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `rx_drop_o`  out  1  one-cycle pulse: a received byte was discarded.

## Operation
- Frame: `CMD ADDR [DATA] [CSUM]`. `CMD` 0x57 ('W') = write, carries DATA; 0x52 ('R') = read, no DATA.
- States: IDLE, ADDR, DATA, CSUM, BUS, WAIT_ACK, REPLY0, REPLY1.
- IDLE, on byte: 0x57/0x52 -> ADDR (latch op). Any other value -> REPLY0 with 0x15 (NAK).
- ADDR, on byte: latch address. Write -> DATA. Read -> CSUM if enabled, else BUS.
- DATA, on byte: latch data. -> CSUM if enabled, else BUS.
- BUS: assert `reg_we_o` or `reg_re_o` for exactly one cycle. -> WAIT_ACK.
- WAIT_ACK:
  - On `reg_ack_i`: write -> REPLY0 with 0x06 (ACK). Read -> REPLY0 with 0x06, then REPLY1 with captured `reg_rdata_i`.
  - No ack after ACK_TIMEOUT cycles: -> REPLY0 with 0x15. A late ack is ignored.
- REPLY0/REPLY1:
  - Hold `tx_valid_o`=1 with a stable byte until `tx_ready_i`.
  - After the last byte is accepted -> IDLE.
- Gap timeout:
  - In ADDR/DATA/CSUM, a 12-bit counter increments on each `x16clk_i` and clears on every `rx_wr_i`.
  - Reaching GAP_TICKS -> IDLE, no reply, frame discarded.
  - Counter is zero on entry to ADDR.
- `rx_wr_i` in BUS/WAIT_ACK/REPLY0/REPLY1: byte discarded, `rx_drop_o` pulses the next cycle, state unaffected.
- `rx_wr_i` in the same cycle the gap timeout fires: the timeout wins, and the byte is dropped with `rx_drop_o`.
- `reg_ack_i` outside WAIT_ACK is ignored.

## Timing
- Reset: all outputs 0, including `tx_data_o`, `reg_addr_o`, `reg_wdata_o`. State IDLE, counters 0. Reset applies mid-frame or mid-reply: the frame is abandoned and `tx_valid_o` drops in the next cycle.
- `rx_wr_i` at cycle N on the final frame byte: state BUS at N+1; strobe at N+1; WAIT_ACK from N+2.
- `reg_ack_i` at cycle M: `tx_valid_o` high at M+1.
- Ack in the same cycle as the timeout expiry: ack wins.
- Reply byte accepted at cycle K (`tx_valid_o`&`tx_ready_i`):
  - Next reply byte valid at K+1.
  - Otherwise IDLE at K+1, and a byte arriving at K+1 is accepted.
- NAK for a bad CMD: `tx_valid_o` at N+1.

## Configuration
- `UART_REG_CTRL_CKSUM_EN` defined:
  - CSUM state active; CSUM = 8-bit modulo-256 sum of all preceding frame bytes.
  - Match -> BUS.
  - Mismatch -> REPLY0 with 0x15; no bus strobe.
- Undefined: CSUM state and sum logic absent; frames end after ADDR (read) or DATA (write).

## Test plan
- Write 0x57,0x10,0xA5 (+CSUM 0x0C if enabled) with ack 3 cycles after strobe -> one `reg_we_o` with addr 0x10, wdata 0xA5; tx byte 0x06.
- Read 0x52,0x22 (+CSUM 0x74), ack with rdata 0x5C, `tx_ready_i` stalled 5 cycles -> `reg_re_o` once; tx bytes 0x06 then 0x5C, each held stable while stalled.
- Byte 0x41 in IDLE -> tx 0x15, no bus strobe. No ack for 255 cycles -> 0x15; a later ack is ignored.
- 0x57 then silence for GAP_TICKS x16 ticks -> returns to IDLE, no tx. Next a valid read frame completes normally.
- Byte sent during WAIT_ACK -> `rx_drop_o` one pulse, reply unchanged. `rst_n_i`=0 during REPLY1 -> `tx_valid_o`=0 next cycle, IDLE.
- CKSUM_EN: write frame with CSUM 0x00 (wrong) -> tx 0x15, `reg_we_o` never asserted.
